// File: rtl/issue_pair_queue_pkg.sv
// rtl/issue_pair_queue_pkg.sv - queue-entry layout and pair-block reason codes for issue_pair_queue
package issue_pair_queue_pkg;

    localparam int RF_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] rdaddr;
        logic [RF_ADDR_WIDTH-1:0] rs1addr;
        logic [RF_ADDR_WIDTH-1:0] rs2addr;
        logic                     rd_wrt_en;
        logic                     ld_en;
        logic                     st_en;
        logic                     br_en;
    } iq_entry_t;

    // One bit per reason so several blocking causes can be seen at once
    localparam int             BLK_W     = 4;
    localparam logic [BLK_W-1:0] BLK_BR    = 4'b0001;
    localparam logic [BLK_W-1:0] BLK_MEM   = 4'b0010;
    localparam logic [BLK_W-1:0] BLK_WAW   = 4'b0100;
    localparam logic [BLK_W-1:0] BLK_LDUSE = 4'b1000;

endpackage

// File: rtl/issue_pair_queue_if.sv
// rtl/issue_pair_queue_if.sv - decode-side and issue-side bundle of issue_pair_queue
interface issue_pair_queue_if
    import issue_pair_queue_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 4
);
    logic [1:0]               dec_valid;
    logic                     dec_ready;
    logic [PC_WIDTH-1:0]      dec_pc_0, dec_pc_1;
    logic [RF_ADDR_WIDTH-1:0] dec_rdaddr_0, dec_rdaddr_1;
    logic [RF_ADDR_WIDTH-1:0] dec_rs1addr_0, dec_rs1addr_1;
    logic [RF_ADDR_WIDTH-1:0] dec_rs2addr_0, dec_rs2addr_1;
    logic                     dec_RdWrtEn_0, dec_RdWrtEn_1;
    logic                     dec_LdEn_0, dec_LdEn_1;
    logic                     dec_StEn_0, dec_StEn_1;
    logic                     dec_BrEn_0, dec_BrEn_1;

    logic                     issue0_valid, issue1_valid;
    logic [PC_WIDTH-1:0]      issue0_pc, issue1_pc;
    logic [RF_ADDR_WIDTH-1:0] issue0_rdaddr, issue1_rdaddr;
    logic [RF_ADDR_WIDTH-1:0] issue0_rs1addr, issue1_rs1addr;
    logic [RF_ADDR_WIDTH-1:0] issue0_rs2addr, issue1_rs2addr;
    logic                     issue0_RdWrtEn, issue1_RdWrtEn;
    logic                     issue0_LdEn, issue1_LdEn;
    logic                     issue0_StEn, issue1_StEn;
    logic                     issue0_BrEn, issue1_BrEn;

    logic [CNT_WIDTH-1:0]     q_count;

    modport master (
        output dec_valid, dec_pc_0, dec_pc_1, dec_rdaddr_0, dec_rdaddr_1,
               dec_rs1addr_0, dec_rs1addr_1, dec_rs2addr_0, dec_rs2addr_1,
               dec_RdWrtEn_0, dec_RdWrtEn_1, dec_LdEn_0, dec_LdEn_1,
               dec_StEn_0, dec_StEn_1, dec_BrEn_0, dec_BrEn_1,
        input  dec_ready, issue0_valid, issue1_valid, issue0_pc, issue1_pc,
               issue0_rdaddr, issue1_rdaddr, issue0_rs1addr, issue1_rs1addr,
               issue0_rs2addr, issue1_rs2addr, issue0_RdWrtEn, issue1_RdWrtEn,
               issue0_LdEn, issue1_LdEn, issue0_StEn, issue1_StEn,
               issue0_BrEn, issue1_BrEn, q_count
    );

    modport slave (
        input  dec_valid, dec_pc_0, dec_pc_1, dec_rdaddr_0, dec_rdaddr_1,
               dec_rs1addr_0, dec_rs1addr_1, dec_rs2addr_0, dec_rs2addr_1,
               dec_RdWrtEn_0, dec_RdWrtEn_1, dec_LdEn_0, dec_LdEn_1,
               dec_StEn_0, dec_StEn_1, dec_BrEn_0, dec_BrEn_1,
        output dec_ready, issue0_valid, issue1_valid, issue0_pc, issue1_pc,
               issue0_rdaddr, issue1_rdaddr, issue0_rs1addr, issue1_rs1addr,
               issue0_rs2addr, issue1_rs2addr, issue0_RdWrtEn, issue1_RdWrtEn,
               issue0_LdEn, issue1_LdEn, issue0_StEn, issue1_StEn,
               issue0_BrEn, issue1_BrEn, q_count
    );

endinterface

// File: rtl/issue_pair_queue_pair_check.sv
// rtl/issue_pair_queue_pair_check.sv - issue_pair_check: pair legality of (A, B); ISSUE_LOADUSE_SPLIT_EN adds the load-use split rule
module issue_pair_check
    import issue_pair_queue_pkg::*;
(
    input  iq_entry_t        a,
    input  iq_entry_t        b,
    output logic [BLK_W-1:0] block
);

`ifdef ISSUE_LOADUSE_SPLIT_EN
    localparam bit LDUSE_SPLIT = 1'b1;
`else
    localparam bit LDUSE_SPLIT = 1'b0;
`endif

    logic lduse_hit;
    logic unused_fields;

    assign lduse_hit = a.ld_en && a.rd_wrt_en && (a.rdaddr != '0) &&
                       ((a.rdaddr == b.rs1addr) || (a.rdaddr == b.rs2addr));
    assign unused_fields = ^{a.rs1addr, a.rs2addr, b.br_en};

    always_comb begin
        block = '0;
        if (a.br_en)
            block = block | BLK_BR;
        // Only one Dcache port, so two memory ops never share a cycle
        if ((a.ld_en || a.st_en) && (b.ld_en || b.st_en))
            block = block | BLK_MEM;
        if (a.rd_wrt_en && b.rd_wrt_en && (a.rdaddr == b.rdaddr) && (a.rdaddr != '0))
            block = block | BLK_WAW;
        if (LDUSE_SPLIT && lduse_hit)
            block = block | BLK_LDUSE;
    end

endmodule

// File: rtl/issue_pair_queue.sv
// rtl/issue_pair_queue.sv - decoded-instruction circular queue with dual-issue pairing slots
module issue_pair_queue
    import issue_pair_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 exforward_stall,
    issue_pair_queue_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] pc;
        iq_entry_t           e;
    } slot_t;

    iq_entry_t           mem    [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem [DEPTH];

    logic [AW-1:0]    head, tail, head_nxt1, tail_nxt1;
    logic [CW-1:0]    count;
    iq_entry_t        lane0, lane1, ent_a, ent_b;
    logic [BLK_W-1:0] pair_block;
    logic             enq_fire, take0, take1;
    logic [1:0]       enq_n, deq_n;
    slot_t            slot0, slot1, cand0, cand1;

    assign lane0 = '{rdaddr: bus.dec_rdaddr_0, rs1addr: bus.dec_rs1addr_0, rs2addr: bus.dec_rs2addr_0,
                     rd_wrt_en: bus.dec_RdWrtEn_0, ld_en: bus.dec_LdEn_0, st_en: bus.dec_StEn_0,
                     br_en: bus.dec_BrEn_0};
    assign lane1 = '{rdaddr: bus.dec_rdaddr_1, rs1addr: bus.dec_rs1addr_1, rs2addr: bus.dec_rs2addr_1,
                     rd_wrt_en: bus.dec_RdWrtEn_1, ld_en: bus.dec_LdEn_1, st_en: bus.dec_StEn_1,
                     br_en: bus.dec_BrEn_1};

    assign head_nxt1 = head + 1'b1;
    assign tail_nxt1 = tail + 1'b1;
    assign ent_a     = mem[head];
    assign ent_b     = mem[head_nxt1];

    issue_pair_check u_pair_check (
        .a     (ent_a),
        .b     (ent_b),
        .block (pair_block)
    );

    // Ready looks only at the registered count; a same-cycle dequeue earns no credit
    assign bus.dec_ready = (count <= CW'(DEPTH - 2));
    assign enq_fire      = bus.dec_ready && bus.dec_valid[0];
    assign enq_n         = !enq_fire ? 2'd0 : (bus.dec_valid[1] ? 2'd2 : 2'd1);
    assign take0         = !exforward_stall && (count != '0);
    assign take1         = take0 && (count >= CW'(2)) && (pair_block == '0);
    assign deq_n         = {1'b0, take0} + {1'b0, take1};

    always_comb begin
        cand0 = '0;
        cand1 = '0;
        if (take0) begin
            cand0.valid = 1'b1;
            cand0.pc    = pc_mem[head];
            cand0.e     = ent_a;
        end
        if (take1) begin
            cand1.valid = 1'b1;
            cand1.pc    = pc_mem[head_nxt1];
            cand1.e     = ent_b;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            mem[tail]    <= lane0;
            pc_mem[tail] <= bus.dec_pc_0;
            if (bus.dec_valid[1]) begin
                mem[tail_nxt1]    <= lane1;
                pc_mem[tail_nxt1] <= bus.dec_pc_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            tail  <= tail + AW'(enq_n);
            head  <= head + AW'(deq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
            if (!exforward_stall) begin
                slot0 <= cand0;
                slot1 <= cand1;
            end
        end
    end

    assign bus.issue0_valid   = slot0.valid;
    assign bus.issue0_pc      = slot0.pc;
    assign bus.issue0_rdaddr  = slot0.e.rdaddr;
    assign bus.issue0_rs1addr = slot0.e.rs1addr;
    assign bus.issue0_rs2addr = slot0.e.rs2addr;
    assign bus.issue0_RdWrtEn = slot0.e.rd_wrt_en;
    assign bus.issue0_LdEn    = slot0.e.ld_en;
    assign bus.issue0_StEn    = slot0.e.st_en;
    assign bus.issue0_BrEn    = slot0.e.br_en;
    assign bus.issue1_valid   = slot1.valid;
    assign bus.issue1_pc      = slot1.pc;
    assign bus.issue1_rdaddr  = slot1.e.rdaddr;
    assign bus.issue1_rs1addr = slot1.e.rs1addr;
    assign bus.issue1_rs2addr = slot1.e.rs2addr;
    assign bus.issue1_RdWrtEn = slot1.e.rd_wrt_en;
    assign bus.issue1_LdEn    = slot1.e.ld_en;
    assign bus.issue1_StEn    = slot1.e.st_en;
    assign bus.issue1_BrEn    = slot1.e.br_en;
    assign bus.q_count        = count;

endmodule

// File: tb/tb_issue_pair_queue.sv
// tb/tb_issue_pair_queue.sv - directed scoreboard bench for issue_pair_queue
module tb_issue_pair_queue;
    import issue_pair_queue_pkg::*;

    localparam int DEPTH    = 8;
    localparam int PC_WIDTH = 32;
    localparam int CW       = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic        we, ld, st, br;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic exforward_stall = 1'b0;
    int   checks = 0;
    int   failures = 0;
    ins_t sb[$];

    always #5 clk = ~clk;

    issue_pair_queue_if #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CW)) bus ();

    issue_pair_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .exforward_stall (exforward_stall),
        .bus             (bus.slave)
    );

    function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic we, input logic ld,
                                input logic st, input logic br);
        return '{pc: pc, rd: rd, rs1: rs1, rs2: rs2, we: we, ld: ld, st: st, br: br};
    endfunction

    function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] rd);
        return mk(pc, rd, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic ins_t obs0();
        return '{pc: bus.issue0_pc, rd: bus.issue0_rdaddr, rs1: bus.issue0_rs1addr, rs2: bus.issue0_rs2addr,
                 we: bus.issue0_RdWrtEn, ld: bus.issue0_LdEn, st: bus.issue0_StEn, br: bus.issue0_BrEn};
    endfunction

    function automatic ins_t obs1();
        return '{pc: bus.issue1_pc, rd: bus.issue1_rdaddr, rs1: bus.issue1_rs1addr, rs2: bus.issue1_rs2addr,
                 we: bus.issue1_RdWrtEn, ld: bus.issue1_LdEn, st: bus.issue1_StEn, br: bus.issue1_BrEn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [1:0] v, input ins_t i0, input ins_t i1);
        bus.dec_valid = v;
        {bus.dec_pc_0, bus.dec_rdaddr_0, bus.dec_rs1addr_0, bus.dec_rs2addr_0,
         bus.dec_RdWrtEn_0, bus.dec_LdEn_0, bus.dec_StEn_0, bus.dec_BrEn_0} = i0;
        {bus.dec_pc_1, bus.dec_rdaddr_1, bus.dec_rs1addr_1, bus.dec_rs2addr_1,
         bus.dec_RdWrtEn_1, bus.dec_LdEn_1, bus.dec_StEn_1, bus.dec_BrEn_1} = i1;
    endtask

    task automatic enq(input logic [1:0] v, input ins_t i0, input ins_t i1);
        set_dec(v, i0, i1);
        if (v[0]) sb.push_back(i0);
        if (v == 2'b11) sb.push_back(i1);
        tick();
        bus.dec_valid = 2'b00;
    endtask

    task automatic check_slots(input logic v0, input logic v1);
        ins_t e;
        chk("issue0_valid", bus.issue0_valid, v0);
        chk("issue1_valid", bus.issue1_valid, v1);
        if (v0) begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chk("issue0_fields", obs0(), e);
        end else begin
            chk("issue0_zero", obs0(), '0);
        end
        if (v1) begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chk("issue1_fields", obs1(), e);
        end else begin
            chk("issue1_zero", obs1(), '0);
        end
    endtask

    task automatic check_held(input ins_t a, input ins_t b, input logic [3:0] cnt);
        chk("held_v0", bus.issue0_valid, 1'b1);
        chk("held_v1", bus.issue1_valid, 1'b1);
        chk("held_slot0", obs0(), a);
        chk("held_slot1", obs1(), b);
        chk("held_q_count", bus.q_count, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t p2a, p2b;
        set_dec(2'b00, '0, '0);

        tick();
        tick();
        chk("rst_q_count", bus.q_count, 4'd0);
        chk("rst_dec_ready", bus.dec_ready, 1'b1);
        check_slots(1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // two ALU ops issue together two edges after being offered
        enq(2'b11, alu(32'h100, 5'd3), alu(32'h104, 5'd4));
        chk("alu_q_count_enq", bus.q_count, 4'd2);
        chk("alu_v0_early", bus.issue0_valid, 1'b0);
        tick();
        check_slots(1'b1, 1'b1);
        chk("alu_q_count_deq", bus.q_count, 4'd0);
        tick();
        check_slots(1'b0, 1'b0);

        set_dec(2'b10, alu(32'h108, 5'd5), alu(32'h10c, 5'd6));
        tick();
        bus.dec_valid = 2'b00;
        chk("lane1_only_ignored", bus.q_count, 4'd0);

        // load rd5 followed by an add reading r5
        enq(2'b11, mk(32'h200, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0),
                   mk(32'h204, 5'd6, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef ISSUE_LOADUSE_SPLIT_EN
        tick(); check_slots(1'b1, 1'b0);
        tick(); check_slots(1'b1, 1'b0);
`else
        tick(); check_slots(1'b1, 1'b1);
`endif
        tick(); check_slots(1'b0, 1'b0);

        enq(2'b11, mk(32'h210, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0),
                   mk(32'h214, 5'd0, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0));
        tick(); check_slots(1'b1, 1'b0);
        tick(); check_slots(1'b1, 1'b0);

        enq(2'b11, mk(32'h220, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1), alu(32'h224, 5'd8));
        tick(); check_slots(1'b1, 1'b0);
        tick(); check_slots(1'b1, 1'b0);

        enq(2'b11, alu(32'h230, 5'd9), alu(32'h234, 5'd9));
        tick(); check_slots(1'b1, 1'b0);
        tick(); check_slots(1'b1, 1'b0);

        enq(2'b11, alu(32'h240, 5'd0), alu(32'h244, 5'd0));
        tick(); check_slots(1'b1, 1'b1);
        tick(); check_slots(1'b0, 1'b0);

        // fill to DEPTH-1 behind a stall; tail wraps past entry 7 here
        exforward_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            enq(2'b11, alu(32'h300 + 32'(8 * i), 5'(10 + 2 * i)), alu(32'h304 + 32'(8 * i), 5'(11 + 2 * i)));
        enq(2'b01, alu(32'h318, 5'd16), '0);
        chk("full_q_count", bus.q_count, 4'd7);
        chk("full_dec_ready", bus.dec_ready, 1'b0);
        set_dec(2'b11, alu(32'h3f0, 5'd30), alu(32'h3f4, 5'd31));
        tick();
        bus.dec_valid = 2'b00;
        chk("full_reject", bus.q_count, 4'd7);
        check_slots(1'b0, 1'b0);
        exforward_stall = 1'b0;
        tick();
        check_slots(1'b1, 1'b1);
        chk("drain_q_count", bus.q_count, 4'd5);
        chk("drain_dec_ready", bus.dec_ready, 1'b1);
        tick(); check_slots(1'b1, 1'b1);
        tick(); check_slots(1'b1, 1'b1);
        tick(); check_slots(1'b1, 1'b0);
        chk("drained_q_count", bus.q_count, 4'd0);
        tick(); check_slots(1'b0, 1'b0);

        // stall window with four queued entries
        p2a = alu(32'h410, 5'd22);
        p2b = alu(32'h414, 5'd23);
        enq(2'b11, alu(32'h400, 5'd20), alu(32'h404, 5'd21));
        enq(2'b11, p2a, p2b);
        check_slots(1'b1, 1'b1);
        enq(2'b11, alu(32'h420, 5'd24), alu(32'h424, 5'd25));
        check_slots(1'b1, 1'b1);
        exforward_stall = 1'b1;
        enq(2'b11, alu(32'h430, 5'd26), alu(32'h434, 5'd27));
        check_held(p2a, p2b, 4'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_held(p2a, p2b, 4'd4);
        end
        enq(2'b11, alu(32'h440, 5'd28), alu(32'h444, 5'd29));
        check_held(p2a, p2b, 4'd6);

        // flush beats a simultaneous enqueue and stall
        set_dec(2'b11, alu(32'h450, 5'd11), alu(32'h454, 5'd12));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exforward_stall = 1'b0;
        bus.dec_valid = 2'b00;
        sb.delete();
        chk("flush_q_count", bus.q_count, 4'd0);
        chk("flush_dec_ready", bus.dec_ready, 1'b1);
        check_slots(1'b0, 1'b0);
        tick();
        check_slots(1'b0, 1'b0);

        // asynchronous reset in the middle of traffic
        enq(2'b11, alu(32'h500, 5'd1), alu(32'h504, 5'd2));
        enq(2'b11, alu(32'h508, 5'd3), alu(32'h50c, 5'd4));
        check_slots(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_q_count", bus.q_count, 4'd0);
        chk("arst_dec_ready", bus.dec_ready, 1'b1);
        check_slots(1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        enq(2'b11, alu(32'h600, 5'd5), alu(32'h604, 5'd6));
        tick();
        check_slots(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_pair_queue.md
# issue_pair_queue

Decoded-instruction buffer and dual-issue pairing stage sitting directly upstream of the EX forwarding logic. It accepts up to two decoded instructions per cycle from decode into a circular queue. Each cycle it selects the oldest one or two entries for issue slots 0 and 1, applying the pairing rules. It drives registered issue0/issue1 fields (rd, rs1, rs2, write-enable, load/store/branch flags) and holds them while `exforward_stall` is asserted.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥4.
- `PC_WIDTH`, 32: program counter width.
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  branch-mispredict/redirect; empties queue and issue slots.
- `exforward_stall`  in  1  EX load-use stall; freezes issue slots and dequeue.
- `dec_valid`  in  2  bit0 = older lane, bit1 = younger lane.
- `dec_ready`  out  1  queue can accept two instructions this cycle.
- `dec_pc_{0,1}`  in  PC_WIDTH  lane PC.
- `dec_rdaddr_{0,1}`, `dec_rs1addr_{0,1}`, `dec_rs2addr_{0,1}`  in  `RF_ADDR_WIDTH`  register addresses.
- `dec_RdWrtEn_{0,1}`, `dec_LdEn_{0,1}`, `dec_StEn_{0,1}`, `dec_BrEn_{0,1}`  in  1  lane flags.
- `issue{0,1}_valid`  out  1  slot holds a live instruction.
- `issue{0,1}_pc`, `issue{0,1}_rdaddr`, `issue{0,1}_rs1addr`, `issue{0,1}_rs2addr`, `issue{0,1}_RdWrtEn`, `issue{0,1}_LdEn`, `issue{0,1}_StEn`, `issue{0,1}_BrEn`  out  as input widths  registered slot fields.
- `q_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH-entry circular buffer; head/tail pointers of $clog2(DEPTH) bits wrap naturally; separate occupancy counter `q_count`.
- Enqueue: fires when `dec_ready && dec_valid[0]`. Lane 0 is written at tail; lane 1 (if `dec_valid[1]`) at tail+1. Tail and count advance by 1 or 2. `dec_valid == 2'b10` is treated as 2'b00 (nothing written).
- `dec_ready` = (DEPTH − q_count) ≥ 2, computed from the registered count. Same-cycle dequeue is not credited.
- Selection (when `!exforward_stall && !flush`): slot 0 loads head entry if q_count ≥ 1. Slot 1 loads head+1 if q_count ≥ 2 and the pair is legal. Otherwise the slot's valid is 0. Head advances and count decrements by the number loaded.
- Pair is illegal (A = head, B = head+1) if any of:
  - A.BrEn;
  - (A.LdEn|A.StEn) && (B.LdEn|B.StEn) (single Dcache port);
  - A.RdWrtEn && B.RdWrtEn && A.rd == B.rd && A.rd != 0 (WAW).
- Fields of invalid slots are driven to zero.
- Stall: `exforward_stall` holds both slots unchanged and suppresses dequeue. Enqueue still proceeds.
- Flush: head, tail and count go to 0 and both slot valids go to 0 at the next edge. Flush overrides a simultaneous enqueue, dequeue and stall.
- Simultaneous enqueue and dequeue: count_next = count + enq_n − deq_n. Entries written this cycle are not selectable until the next cycle.

## Timing
- Reset: all outputs 0, `dec_ready` = 1, pointers and count 0.
- Latency: an instruction accepted at edge k appears on issue outputs after edge k+1 at the earliest.
- Issue outputs change only at clock edges. They are stable for the entire stall window.
- Reset mid-operation clears everything asynchronously, identical to flush.
- Full queue: q_count = DEPTH − 1 or DEPTH → `dec_ready` = 0. Empty queue: both slot valids go to 0 at the next unstalled edge.

## Configuration
- `ISSUE_LOADUSE_SPLIT_EN` defined: an extra illegal-pair rule applies. The rule is A.LdEn && A.RdWrtEn && A.rd != 0 && (A.rd == B.rs1 || A.rd == B.rs2). B then issues alone one cycle later, so EX never asserts `exforward_stall` for an intra-pair load-use.
- Undefined: load-use pairs issue together, and EX resolves them via `exforward_stall` plus Dcache forwarding.

## Structure
- Shared header/package (alongside `RF_ADDR_WIDTH`): queue-entry field layout and widths, plus the pair-block reason constants (BR, MEM, WAW, LDUSE) used in assertions.
- One sub-module `issue_pair_check`: combinational legality of (A, B). It contains the macro-controlled load-use rule. The top holds storage, pointers, count and slot registers.

## Test plan
- Reset then enqueue two ALU ops (rd 3, rd 4) → after 2 edges both slots valid, q_count 0.
- Enqueue load rd=5 with add rs1=5, macro on → slot0 = load alone, slot1 = add on the next edge. Macro off → both in the same cycle.
- Enqueue ld then sd → issued on separate cycles. Enqueue branch then add → branch alone in slot0.
- Fill to 7 entries (DEPTH 8) → `dec_ready` 0. Dequeue 2 → `dec_ready` 1. Pointers wrap past entry 7 with order preserved.
- Hold `exforward_stall` 3 cycles with 4 queued → slot outputs unchanged, q_count unchanged. Enqueue of 2 during the stall → q_count 6.
- Assert `flush` together with enqueue and stall → next edge q_count 0, both valids 0. Assert `rst_n` low mid-stream → immediate all-zero outputs.
